// File: rtl/stage4_instr_queue_pkg.sv
// Shared pipeline types for the fetch/decode instruction queue.
// Provides word_t, the queue entry layout and the default queue depth.
// Imported by stage4_instr_queue_if and stage4_instr_queue.
package stage4_instr_queue_pkg;

  typedef logic [31:0] word_t;

  // One buffered fetch result: address, raw word, predictor hint, fault flags.
  typedef struct packed {
    word_t pc;
    word_t instr;
    logic  pred_taken;
    logic  fault;
    logic  mal;
  } fetch_queue_entry_t;

  // Default number of queue entries (power of two, >= 2).
  localparam int IQ_DEPTH = 4;

endpackage

// File: rtl/stage4_instr_queue_if.sv
// Bundle of fetch push side, hazard control and decode head side of the queue.
// master: fetch / hazard unit / decode (drives push, flush, stall, pop).
// slave:  the queue (drives full, count and the head entry out_*).
interface stage4_instr_queue_if
  import stage4_instr_queue_pkg::*;
#(
  parameter int DEPTH = IQ_DEPTH
);

  // Fetch side
  logic  push;
  word_t push_pc;
  word_t push_instr;
  logic  push_pred_taken;
  logic  push_fault;
  logic  push_mal;

  // Hazard unit control
  logic flush;
  logic stall;

  // Decode side
  logic pop;
  logic  out_valid;
  word_t out_pc;
  word_t out_instr;
  logic  out_pred_taken;
  logic  out_fault;
  logic  out_mal;

  // Status
  logic                     full;
  logic [$clog2(DEPTH):0]   count;

  modport master (
    output push, push_pc, push_instr, push_pred_taken, push_fault, push_mal,
    output flush, stall, pop,
    input  out_valid, out_pc, out_instr, out_pred_taken, out_fault, out_mal,
    input  full, count
  );

  modport slave (
    input  push, push_pc, push_instr, push_pred_taken, push_fault, push_mal,
    input  flush, stall, pop,
    output out_valid, out_pc, out_instr, out_pred_taken, out_fault, out_mal,
    output full, count
  );

endinterface

// File: rtl/stage4_instr_queue.sv
// Instruction queue between fetch and decode: circular buffer of DEPTH entries.
// Ports: CLK, RST (async active-high); q (slave modport) carries push_*, flush,
// stall, pop in and full, count, out_valid, out_* (head entry) out.
// Latency: push to head is one cycle; with INSTR_QUEUE_BYPASS_EN defined an
// empty queue forwards push_* to out_* combinationally (zero cycles).
// Backpressure: pushes while full are dropped; pops are ignored when empty or
// stalled; flush empties the queue and discards a same-cycle push.
module stage4_instr_queue
  import stage4_instr_queue_pkg::*;
#(
  parameter int DEPTH = IQ_DEPTH
) (
  input logic              CLK,
  input logic              RST,
  stage4_instr_queue_if.slave q
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  fetch_queue_entry_t mem [DEPTH];

  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [CW-1:0] cnt;

  fetch_queue_entry_t push_entry;
  fetch_queue_entry_t head;

  logic full;
  logic empty;
  logic out_valid;
  logic bypass;
  logic push_acc;
  logic pop_acc;
  logic wr_en;
  logic rd_en;

  assign push_entry = '{pc:         q.push_pc,
                        instr:      q.push_instr,
                        pred_taken: q.push_pred_taken,
                        fault:      q.push_fault,
                        mal:        q.push_mal};

  assign full  = (cnt == CW'(DEPTH));
  assign empty = (cnt == '0);

`ifdef INSTR_QUEUE_BYPASS_EN
  // An empty queue presents the incoming entry directly at the head.
  assign bypass = empty & q.push & ~q.flush;
`else
  assign bypass = 1'b0;
`endif

  assign out_valid = ~empty | bypass;
  assign push_acc  = q.push & ~full & ~q.flush;
  assign pop_acc   = q.pop & out_valid & ~q.stall & ~q.flush;

  // A bypassed entry consumed in the same cycle never touches storage, so
  // neither pointer moves and the count stays at zero.
  assign wr_en = push_acc & ~(bypass & pop_acc);
  assign rd_en = pop_acc  & ~bypass;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else if (q.flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + PW'(1);
      if (rd_en) rd_ptr <= rd_ptr + PW'(1);
      case ({wr_en, rd_en})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  // Storage is not reset or cleared on flush; out_valid gates what is visible.
  always_ff @(posedge CLK) begin
    if (wr_en && !q.flush) mem[wr_ptr] <= push_entry;
  end

  always_comb begin
    head = '0;
    if (bypass)         head = push_entry;
    else if (out_valid) head = mem[rd_ptr];
  end

  assign q.out_valid      = out_valid;
  assign q.out_pc         = head.pc;
  assign q.out_instr      = head.instr;
  assign q.out_pred_taken = head.pred_taken;
  assign q.out_fault      = head.fault;
  assign q.out_mal        = head.mal;
  assign q.full           = full;
  assign q.count          = cnt;

endmodule

// File: tb/tb_stage4_instr_queue.sv
module tb_stage4_instr_queue;
  import stage4_instr_queue_pkg::*;

  localparam logic Y = 1'b1;
  localparam logic N = 1'b0;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  always #5 CLK = ~CLK;

  stage4_instr_queue_if #(.DEPTH(4)) qif ();

  stage4_instr_queue #(.DEPTH(4)) dut (
    .CLK (CLK),
    .RST (RST),
    .q   (qif)
  );

  int n_chk  = 0;
  int n_fail = 0;
  int proto_err = 0;

  // Pushes presented while the queue is full are protocol errors.
  always @(posedge CLK) begin
    if (!RST && qif.push && qif.full) proto_err++;
  end

  typedef struct {
    logic        push;
    logic [31:0] pc;
    logic        fault;
    logic        pop;
    logic        stall;
    logic [31:0] exp_cnt;
    logic        exp_vld;
    logic        exp_full;
    logic [31:0] exp_pc;
  } vec_t;

  vec_t tv [13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic push, input logic [31:0] pc, input logic fault,
                       input logic pop, input logic stall, input logic flush);
    qif.push            = push;
    qif.push_pc         = pc;
    qif.push_instr      = ~pc;
    qif.push_pred_taken = pc[2];
    qif.push_fault      = fault;
    qif.push_mal        = pc[3];
    qif.pop             = pop;
    qif.stall           = stall;
    qif.flush           = flush;
  endtask

  task automatic idle();
    drive(N, 32'h0, N, N, N, N);
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk_state(input string tag, input logic [31:0] c, input logic v,
                           input logic f, input logic [31:0] pc);
    chk({tag, ".count"},     32'(qif.count), c);
    chk({tag, ".out_valid"}, 32'(qif.out_valid), 32'(v));
    chk({tag, ".full"},      32'(qif.full), 32'(f));
    chk({tag, ".out_pc"},    qif.out_pc, pc);
  endtask

  initial begin
    // push, pc, fault, pop, stall -> count, valid, full, head pc
    tv[0]  = '{Y, 32'h100, N, N, N, 32'd1, Y, N, 32'h100};
    tv[1]  = '{Y, 32'h104, N, N, N, 32'd2, Y, N, 32'h100};
    tv[2]  = '{Y, 32'h108, N, N, N, 32'd3, Y, N, 32'h100};
    tv[3]  = '{Y, 32'h10C, N, N, N, 32'd4, Y, Y, 32'h100};
    tv[4]  = '{Y, 32'h110, N, N, N, 32'd4, Y, Y, 32'h100};
    tv[5]  = '{N, 32'h0,   N, Y, Y, 32'd4, Y, Y, 32'h100};
    tv[6]  = '{N, 32'h0,   N, Y, Y, 32'd4, Y, Y, 32'h100};
    tv[7]  = '{N, 32'h0,   N, Y, Y, 32'd4, Y, Y, 32'h100};
    tv[8]  = '{N, 32'h0,   N, Y, N, 32'd3, Y, N, 32'h104};
    tv[9]  = '{N, 32'h0,   N, Y, N, 32'd2, Y, N, 32'h108};
    tv[10] = '{N, 32'h0,   N, Y, N, 32'd1, Y, N, 32'h10C};
    tv[11] = '{N, 32'h0,   N, Y, N, 32'd0, N, N, 32'h0};
    tv[12] = '{N, 32'h0,   N, Y, N, 32'd0, N, N, 32'h0};

    idle();
    #2;
    chk_state("reset_async", 32'd0, N, N, 32'h0);
    tick();
    tick();
    chk_state("reset", 32'd0, N, N, 32'h0);
    chk("reset.out_fault", 32'(qif.out_fault), 32'd0);
    RST = 1'b0;
    tick();

    // Fill, overflow, stalled pops, drain.
    for (int i = 0; i < 13; i++) begin
      drive(tv[i].push, tv[i].pc, tv[i].fault, tv[i].pop, tv[i].stall, N);
      tick();
      idle();
      chk_state($sformatf("vec%0d", i), tv[i].exp_cnt, tv[i].exp_vld, tv[i].exp_full, tv[i].exp_pc);
      if (tv[i].exp_vld)
        chk($sformatf("vec%0d.out_instr", i), qif.out_instr, ~tv[i].exp_pc);
    end
    chk("proto_err_push_full", 32'(proto_err), 32'd1);

    // Sustained push+pop, crossing pointer wrap several times.
`ifdef INSTR_QUEUE_BYPASS_EN
    for (int i = 0; i < 20; i++) begin
      drive(Y, 32'h1000 + 32'(4 * i), N, Y, N, N);
      #1;
      chk($sformatf("stream%0d.head", i), qif.out_pc, 32'h1000 + 32'(4 * i));
      tick();
      chk($sformatf("stream%0d.count", i), 32'(qif.count), 32'd0);
    end
    idle();
`else
    drive(Y, 32'h1000, N, N, N, N);
    tick();
    for (int i = 1; i <= 20; i++) begin
      drive(Y, 32'h1000 + 32'(4 * i), N, Y, N, N);
      #1;
      chk($sformatf("stream%0d.head", i), qif.out_pc, 32'h1000 + 32'(4 * (i - 1)));
      tick();
      chk($sformatf("stream%0d.count", i), 32'(qif.count), 32'd1);
    end
    drive(N, 32'h0, N, Y, N, N);
    tick();
    idle();
    chk("stream.drained", 32'(qif.count), 32'd0);
`endif

    // Flush with three entries held plus a same-cycle push.
    for (int i = 0; i < 3; i++) begin
      drive(Y, 32'h400 + 32'(4 * i), N, N, N, N);
      tick();
    end
    idle();
    chk("flush.pre_count", 32'(qif.count), 32'd3);
    drive(Y, 32'h40C, N, N, N, Y);
    tick();
    idle();
    chk_state("flush", 32'd0, N, N, 32'h0);
    drive(Y, 32'h200, N, N, N, N);
    tick();
    idle();
    chk_state("post_flush_push", 32'd1, Y, N, 32'h200);
    drive(N, 32'h0, N, Y, N, N);
    tick();
    idle();

    // Faulting fetch into an empty queue.
    drive(Y, 32'h300, Y, N, N, N);
`ifdef INSTR_QUEUE_BYPASS_EN
    #1;
    chk("fault.bypass_pc",    qif.out_pc, 32'h300);
    chk("fault.bypass_fault", 32'(qif.out_fault), 32'd1);
`endif
    tick();
    idle();
    chk_state("fault", 32'd1, Y, N, 32'h300);
    chk("fault.out_fault", 32'(qif.out_fault), 32'd1);
    drive(N, 32'h0, N, Y, N, N);
    tick();
    idle();
    chk("fault.popped", 32'(qif.count), 32'd0);
    // Push and pop together on an empty queue.
    drive(Y, 32'h304, N, Y, N, N);
    tick();
    idle();
`ifdef INSTR_QUEUE_BYPASS_EN
    chk("empty_push_pop.count", 32'(qif.count), 32'd0);
`else
    chk("empty_push_pop.count", 32'(qif.count), 32'd1);
    chk("empty_push_pop.head", qif.out_pc, 32'h304);
    drive(N, 32'h0, N, Y, N, N);
    tick();
    idle();
`endif

    // Asynchronous reset mid-cycle with two entries held.
    drive(Y, 32'h500, N, N, N, N);
    tick();
    drive(Y, 32'h504, N, N, N, N);
    tick();
    idle();
    chk("arst.pre_count", 32'(qif.count), 32'd2);
    #2;
    RST = 1'b1;
    #1;
    chk_state("arst", 32'd0, N, N, 32'h0);
    #2;
    RST = 1'b0;
    tick();
    chk_state("arst.after", 32'd0, N, N, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
